rotr_sched: RTL and testbench
=============================

# rotr_sched

Round-robin scheduler that shares one registered 256-bit rotate-right datapath (`Rotr`) between two requesters in the BMI ALU. It accepts a request per valid/ready handshake, converts rotate-left requests to the equivalent right-rotate amount, and holds operands on the rotator for its pipeline latency. It captures the result and returns it, tagged with the requester ID, over a valid/ready response channel. One operation is in flight at a time.

## Interface
Parameters:
- `DATA_WIDTH`, 256: operand width. Only 256 is supported, because the shift amount is 8 bits.
- `ROT_LATENCY`, 1: number of cycles `rot_enable` must be held high before the rotator's registered output is valid. Must be ≥1.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 is granted; the handshake completes when it and `req0_valid` are both high.
- `req0_data` in DATA_WIDTH: operand.
- `req0_shamt` in 8: rotate amount.
- `req0_left` in 1: 1 = rotate left, 0 = rotate right.
- `req1_valid`, `req1_ready`, `req1_data`, `req1_shamt`, `req1_left`: same as requester 0, for requester 1.
- `rot_enable` out 1: drives `Rotr.enable`.
- `rot_a` out DATA_WIDTH: drives `Rotr.a_in`.
- `rot_shift` out DATA_WIDTH: drives `Rotr.shift_in`. Bits [7:0] carry the amount; the upper bits are 0.
- `rot_result` in DATA_WIDTH: from `Rotr.a_out`.
- `resp_valid` out 1: a result is available.
- `resp_ready` in 1: the consumer accepts the result.
- `resp_data` out DATA_WIDTH: the rotated value.
- `resp_id` out 1: the requester that issued the operation.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
FSM states: IDLE, EXEC, CAPT, RESP.

- **IDLE**
  - Arbitrates among the valid requesters using round robin. The `last` pointer resets to 1, so requester 0 wins the first contest.
  - Only one requester is valid: that requester is granted.
  - Both are valid: the requester not equal to `last` is granted.
  - `reqX_ready` is 1 only for the granted requester. It is combinational from the state and the valids, and is 0 outside IDLE.
  - On the handshake:
    - Register the operand into `rot_a`.
    - Register the amount: `shamt` for a right rotate; `(8'd0 - shamt)` (mod 256) for a left rotate. Left by 0 gives 0.
    - Record `resp_id`, update `last`, and go to EXEC.
- **EXEC**
  - `rot_enable` = 1. `rot_a` and `rot_shift` are held stable.
  - A counter runs from 0 to ROT_LATENCY-1. After ROT_LATENCY cycles, go to CAPT.
- **CAPT**
  - `rot_enable` = 0. Operands are still held.
  - Sample `rot_result` into `resp_data`, then go to RESP.
- **RESP**
  - `resp_valid` = 1. `resp_data` and `resp_id` are held stable until `resp_ready` is sampled high.
  - Then go to IDLE. No new request is granted in the cycle the response is accepted.

Other rules:
- `rot_a`, `rot_shift`, `resp_data` and `resp_id` keep their values outside the states that update them.
- Reset (`rst_n` low at an edge), in any state:
  - Go to IDLE and set `last` = 1.
  - Clear `rot_enable`, `resp_valid`, `resp_data`, `resp_id`, `rot_a` and `rot_shift` to 0.
  - Any in-flight operation is dropped with no response.
  - While `rst_n` is low, both `reqX_ready` are forced to 0.

## Timing
- Reset value of every output: 0. This covers both `reqX_ready`, `rot_enable`, `rot_a`, `rot_shift`, `resp_valid`, `resp_data`, `resp_id` and `busy`.
- Handshake at cycle T:
  - `rot_enable` is high in cycles T+1 … T+ROT_LATENCY.
  - CAPT is cycle T+ROT_LATENCY+1.
  - `resp_valid` is first high in cycle T+ROT_LATENCY+2.
- Minimum issue interval (with `resp_ready` held high) is ROT_LATENCY+3 cycles. With ROT_LATENCY=1 that is 4 cycles.
- `resp_ready` low stalls RESP indefinitely. Requests wait; `reqX_ready` stays 0.
- A requester may drop `valid` before it is granted. Arbitration uses only the current-cycle valids.

## Test plan
- **Single right rotate.** After reset, req0: data = 256'h1, shamt = 1, left = 0 → `req0_ready` is high the same cycle. `rot_shift[7:0]` = 1. With ROT_LATENCY=1, `resp_valid` rises 3 cycles after the handshake. `resp_data` = 1<<255. `resp_id` = 0.
- **Left conversion.** req1: data = 256'h1, shamt = 4, left = 1 → `rot_shift[7:0]` = 252 and `resp_data` = 256'h10. Also: left with shamt = 0 → `rot_shift` = 0 and `resp_data` = data.
- **Fairness.** Both valids held high continuously, `resp_ready` = 1 → grants alternate 0, 1, 0, 1. Each grant is 4 cycles apart, and `resp_id` alternates to match.
- **Back-pressure.** `resp_ready` = 0 for 10 cycles during RESP → `resp_valid`, `resp_data` and `resp_id` stay constant and `reqX_ready` stays 0. The response completes in the cycle `resp_ready` goes high, and the next grant comes one cycle later.
- **Reset mid-operation.** `rst_n` = 0 in an EXEC cycle → all outputs are 0 the next cycle and no response is ever produced. After release with both requesters valid, requester 0 is granted first.
- **Latency parameter.** Run with ROT_LATENCY=3 → `rot_enable` is high for exactly 3 cycles and `resp_valid` rises 5 cycles after the handshake.

Source files
------------

// File: rtl/rotr_sched.sv
// rtl/rotr_sched.sv - round-robin scheduler sharing one registered rotate-right unit between two requesters
module rotr_sched #(
    parameter int DATA_WIDTH  = 256,
    parameter int ROT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic [7:0]            req0_shamt,
    input  logic                  req0_left,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic [7:0]            req1_shamt,
    input  logic                  req1_left,
    output logic                  rot_enable,
    output logic [DATA_WIDTH-1:0] rot_a,
    output logic [DATA_WIDTH-1:0] rot_shift,
    input  logic [DATA_WIDTH-1:0] rot_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_id,
    output logic                  busy
);

    localparam int CNT_W = (ROT_LATENCY > 1) ? $clog2(ROT_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROT_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic                    last;
    logic [7:0]              shamt;
    logic                    grant0;
    logic                    grant1;
    logic                    take;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [7:0]              sel_shamt;
    logic                    sel_left;
    logic [7:0]              sel_amt;

    // Both valid: the requester other than the last one served wins.
    always_comb begin
        grant0    = req0_valid && (!req1_valid || last);
        grant1    = req1_valid && (!req0_valid || !last);
        take      = (state == IDLE) && (grant0 || grant1);
        sel_data  = grant1 ? req1_data  : req0_data;
        sel_shamt = grant1 ? req1_shamt : req0_shamt;
        sel_left  = grant1 ? req1_left  : req0_left;
        sel_amt   = sel_left ? (8'd0 - sel_shamt) : sel_shamt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = EXEC;
            EXEC:    if (cnt == CNT_LAST) state_next = CAPT;
            CAPT:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = rst_n && (state == IDLE) && grant0;
        req1_ready = rst_n && (state == IDLE) && grant1;
        rot_enable = (state == EXEC);
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            last      <= 1'b1;
            rot_a     <= '0;
            shamt     <= '0;
            resp_data <= '0;
            resp_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        rot_a   <= sel_data;
                        shamt   <= sel_amt;
                        resp_id <= grant1;
                        last    <= grant1;
                        cnt     <= '0;
                    end
                end
                EXEC:    cnt <= cnt + 1'b1;
                CAPT:    resp_data <= rot_result;
                default: ;
            endcase
        end
    end

    assign rot_shift = {{(DATA_WIDTH-8){1'b0}}, shamt};

endmodule

// File: tb/tb_rotr_sched.sv
// tb/tb_rotr_sched.sv - self-checking bench for rotr_sched with latency 1 and latency 3 instances
module tb_rotr_sched;

    localparam int DW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, v0, v1, l0, l1, resp_ready;
    logic [DW-1:0] d0, d1;
    logic [7:0]    s0, s1;

    logic          req0_ready [2];
    logic          req1_ready [2];
    logic          rot_enable [2];
    logic          resp_valid [2];
    logic          resp_id    [2];
    logic          busy       [2];
    logic [DW-1:0] rot_a      [2];
    logic [DW-1:0] rot_shift  [2];
    logic [DW-1:0] rot_result [2];
    logic [DW-1:0] resp_data  [2];

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] ref_rot(input logic [DW-1:0] d, input logic [7:0] s, input logic left);
        logic [2*DW-1:0] w;
        w = {d, d};
        if (left) begin
            w = w << s;
            return w[2*DW-1:DW];
        end
        w = w >> s;
        return w[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    generate
        for (genvar k = 0; k < 2; k++) begin : g_dut
            localparam int LAT = (k == 0) ? 1 : 3;
            logic [DW-1:0] pipe [0:2];

            rotr_sched #(.DATA_WIDTH(DW), .ROT_LATENCY(LAT)) dut (
                .clk(clk), .rst_n(rst_n),
                .req0_valid(v0), .req0_ready(req0_ready[k]), .req0_data(d0), .req0_shamt(s0), .req0_left(l0),
                .req1_valid(v1), .req1_ready(req1_ready[k]), .req1_data(d1), .req1_shamt(s1), .req1_left(l1),
                .rot_enable(rot_enable[k]), .rot_a(rot_a[k]), .rot_shift(rot_shift[k]), .rot_result(rot_result[k]),
                .resp_valid(resp_valid[k]), .resp_ready(resp_ready), .resp_data(resp_data[k]),
                .resp_id(resp_id[k]), .busy(busy[k])
            );

            // Rotator stand-in: result emerges after LAT enabled cycles.
            always @(posedge clk) begin
                if (rot_enable[k]) begin
                    pipe[0] <= ref_rot(rot_a[k], rot_shift[k][7:0], 1'b0);
                    pipe[1] <= pipe[0];
                    pipe[2] <= pipe[1];
                end
            end
            assign rot_result[k] = pipe[LAT-1];
        end
    endgenerate

    task automatic do_reset();
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_resp(input int k, inout int n);
        while (resp_valid[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; resp_ready = 1'b0;
        d0 = rand_data(); d1 = rand_data();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({req0_ready[k], req1_ready[k], rot_enable[k], resp_valid[k], resp_id[k], busy[k]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d] got %b exp 000000", k,
                         {req0_ready[k], req1_ready[k], rot_enable[k], resp_valid[k], resp_id[k], busy[k]});
            end
            checks++;
            if (rot_a[k] !== '0 || rot_shift[k] !== '0 || resp_data[k] !== '0) begin
                errors++;
                $display("FAIL reset_data[%0d] got a=%h shift=%h data=%h exp 0", k, rot_a[k], rot_shift[k], resp_data[k]);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({req0_ready[k], req1_ready[k]} !== 2'b10) begin
                errors++;
                $display("FAIL reset_first_grant[%0d] got %b exp 10", k, {req0_ready[k], req1_ready[k]});
            end
        end
        v0 = 1'b0; v1 = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_right();
        int n;
        do_reset();
        d0 = 256'h1; s0 = 8'd1; l0 = 1'b0; v0 = 1'b1;
        #1;
        checks++;
        if ({req0_ready[0], req1_ready[0]} !== 2'b10) begin
            errors++; $display("FAIL single_ready got %b exp 10", {req0_ready[0], req1_ready[0]});
        end
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        checks++;
        if (rot_shift[0] !== 256'd1 || rot_enable[0] !== 1'b1 || rot_a[0] !== 256'h1) begin
            errors++; $display("FAIL single_exec got shift=%h en=%b a=%h exp shift=1 en=1 a=1", rot_shift[0], rot_enable[0], rot_a[0]);
        end
        n = 1;
        wait_resp(0, n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL single_latency got %0d exp 3", n); end
        checks++;
        if (resp_data[0] !== {1'b1, 255'b0} || resp_id[0] !== 1'b0) begin
            errors++; $display("FAIL single_resp got data=%h id=%b exp data=%h id=0", resp_data[0], resp_id[0], {1'b1, 255'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_left();
        int n;
        do_reset();
        d1 = 256'h1; s1 = 8'd4; l1 = 1'b1; v1 = 1'b1;
        #1;
        checks++;
        if ({req0_ready[0], req1_ready[0]} !== 2'b01) begin
            errors++; $display("FAIL left_ready got %b exp 01", {req0_ready[0], req1_ready[0]});
        end
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        checks++;
        if (rot_shift[0] !== 256'd252) begin errors++; $display("FAIL left_shift got %0d exp 252", rot_shift[0]); end
        n = 1;
        wait_resp(0, n);
        checks++;
        if (resp_data[0] !== 256'h10 || resp_id[0] !== 1'b1) begin
            errors++; $display("FAIL left_resp got data=%h id=%b exp data=10 id=1", resp_data[0], resp_id[0]);
        end
        @(negedge clk);
        d0 = rand_data(); s0 = 8'd0; l0 = 1'b1; v0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        checks++;
        if (rot_shift[0] !== '0) begin errors++; $display("FAIL left0_shift got %0d exp 0", rot_shift[0]); end
        n = 1;
        wait_resp(0, n);
        checks++;
        if (resp_data[0] !== d0) begin errors++; $display("FAIL left0_data got %h exp %h", resp_data[0], d0); end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int gid[$];
        int gcyc[$];
        int pend[$];
        int id;
        do_reset();
        d0 = rand_data(); d1 = rand_data(); s0 = 8'($urandom); s1 = 8'($urandom);
        l0 = 1'($urandom); l1 = 1'($urandom); v0 = 1'b1; v1 = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (req0_ready[0] === 1'b1) begin gid.push_back(0); gcyc.push_back(cyc); pend.push_back(0); end
            if (req1_ready[0] === 1'b1) begin gid.push_back(1); gcyc.push_back(cyc); pend.push_back(1); end
            if (resp_valid[0] === 1'b1) begin
                id = (pend.size() > 0) ? pend.pop_front() : -1;
                checks++;
                if (id < 0 || resp_id[0] !== 1'(id) || resp_data[0] !== (id == 1 ? ref_rot(d1, s1, l1) : ref_rot(d0, s0, l0))) begin
                    errors++; $display("FAIL fair_resp cyc %0d got id=%b data=%h exp id=%0d", cyc, resp_id[0], resp_data[0], id);
                end
            end
            @(negedge clk);
        end
        v0 = 1'b0; v1 = 1'b0;
        checks++;
        if (gid.size() < 4) begin errors++; $display("FAIL fair_count got %0d exp >=4", gid.size()); end
        for (int i = 0; i < 4 && i < gid.size(); i++) begin
            checks++;
            if (gid[i] != i % 2) begin errors++; $display("FAIL fair_order[%0d] got %0d exp %0d", i, gid[i], i % 2); end
            if (i > 0) begin
                checks++;
                if (gcyc[i] - gcyc[i-1] != 4) begin
                    errors++; $display("FAIL fair_interval[%0d] got %0d exp 4", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        int n;
        logic [DW-1:0] exp;
        do_reset();
        d0 = rand_data(); s0 = 8'($urandom); l0 = 1'($urandom); v0 = 1'b1; resp_ready = 1'b0;
        exp = ref_rot(d0, s0, l0);
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b1; d1 = rand_data();
        n = 1;
        wait_resp(0, n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL bp_latency got %0d exp 3", n); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({resp_valid[0], resp_id[0], req0_ready[0], req1_ready[0]} !== 4'b1000 || resp_data[0] !== exp) begin
                errors++; $display("FAIL bp_hold cyc %0d got v/id/r0/r1=%b data=%h exp 1000 data=%h", i,
                                   {resp_valid[0], resp_id[0], req0_ready[0], req1_ready[0]}, resp_data[0], exp);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if ({resp_valid[0], req1_ready[0]} !== 2'b10) begin
            errors++; $display("FAIL bp_accept got v/r1=%b exp 10", {resp_valid[0], req1_ready[0]});
        end
        @(negedge clk);
        checks++;
        if ({resp_valid[0], req1_ready[0]} !== 2'b01) begin
            errors++; $display("FAIL bp_next_grant got v/r1=%b exp 01", {resp_valid[0], req1_ready[0]});
        end
        v1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        d0 = rand_data() | 256'h1; s0 = 8'($urandom); l0 = 1'($urandom); v0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        checks++;
        if (rot_enable[0] !== 1'b1) begin errors++; $display("FAIL mid_exec got en=%b exp 1", rot_enable[0]); end
        rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({req0_ready[0], req1_ready[0], rot_enable[0], resp_valid[0], resp_id[0], busy[0]} !== 6'b0 ||
            rot_a[0] !== '0 || rot_shift[0] !== '0 || resp_data[0] !== '0) begin
            errors++; $display("FAIL mid_clear got ctrl=%b a=%h shift=%h exp all 0",
                               {req0_ready[0], req1_ready[0], rot_enable[0], resp_valid[0], resp_id[0], busy[0]}, rot_a[0], rot_shift[0]);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({req0_ready[0], req1_ready[0]} !== 2'b10) begin
            errors++; $display("FAIL mid_first_grant got %b exp 10", {req0_ready[0], req1_ready[0]});
        end
        v0 = 1'b0; v1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid[0] !== 1'b0 || busy[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_no_resp got activity=1 exp 0"); end
    endtask

    task automatic test_latency();
        logic [8:0]    mask;
        int            first_v;
        logic [DW-1:0] got;
        do_reset();
        d1 = rand_data(); s1 = 8'($urandom); l1 = 1'($urandom); v1 = 1'b1;
        #1;
        checks++;
        if (req1_ready[1] !== 1'b1) begin errors++; $display("FAIL lat_ready got %b exp 1", req1_ready[1]); end
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        mask = '0; first_v = 0; got = '0;
        for (int c = 1; c <= 8; c++) begin
            mask[c] = rot_enable[1];
            if (resp_valid[1] === 1'b1 && first_v == 0) begin first_v = c; got = resp_data[1]; end
            @(negedge clk);
        end
        checks++;
        if (mask !== 9'b000001110) begin errors++; $display("FAIL lat_enable got %b exp 000001110", mask); end
        checks++;
        if (first_v != 5) begin errors++; $display("FAIL lat_resp_cycle got %0d exp 5", first_v); end
        checks++;
        if (got !== ref_rot(d1, s1, l1)) begin errors++; $display("FAIL lat_data got %h exp %h", got, ref_rot(d1, s1, l1)); end
    endtask

    task automatic test_random();
        bit            busy_m [2];
        bit            acc    [2];
        bit            last_m [2];
        bit            eid    [2];
        int            age    [2];
        int            g      [2];
        logic [DW-1:0] ed     [2];
        do_reset();
        for (int k = 0; k < 2; k++) begin busy_m[k] = 0; last_m[k] = 1; age[k] = 0; eid[k] = 0; ed[k] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            v0 = ($urandom_range(0, 9) < 6); v1 = ($urandom_range(0, 9) < 6);
            d0 = rand_data(); d1 = rand_data(); s0 = 8'($urandom); s1 = 8'($urandom);
            l0 = 1'($urandom); l1 = 1'($urandom); resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                int lat;
                bit evalid, eenable;
                lat = (k == 0) ? 1 : 3;
                g[k] = -1;
                if (!busy_m[k]) begin
                    if (v0 && v1) g[k] = last_m[k] ? 0 : 1;
                    else if (v0)  g[k] = 0;
                    else if (v1)  g[k] = 1;
                end
                evalid  = busy_m[k] && age[k] >= lat + 2;
                eenable = busy_m[k] && age[k] >= 1 && age[k] <= lat;
                checks++;
                if ({req0_ready[k], req1_ready[k]} !== {g[k] == 0, g[k] == 1}) begin
                    errors++; $display("FAIL rand_ready[%0d] cyc %0d got %b exp %b", k, cyc,
                                       {req0_ready[k], req1_ready[k]}, {g[k] == 0, g[k] == 1});
                end
                checks++;
                if ({resp_valid[k], rot_enable[k], busy[k]} !== {evalid, eenable, busy_m[k]}) begin
                    errors++; $display("FAIL rand_ctrl[%0d] cyc %0d got v/en/busy=%b exp %b", k, cyc,
                                       {resp_valid[k], rot_enable[k], busy[k]}, {evalid, eenable, busy_m[k]});
                end
                if (evalid) begin
                    checks++;
                    if (resp_data[k] !== ed[k] || resp_id[k] !== eid[k]) begin
                        errors++; $display("FAIL rand_resp[%0d] cyc %0d got id=%b data=%h exp id=%b data=%h", k, cyc,
                                           resp_id[k], resp_data[k], eid[k], ed[k]);
                    end
                end
                acc[k] = evalid && resp_ready;
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) busy_m[k] = 0;
                if (g[k] >= 0) begin
                    busy_m[k] = 1;
                    age[k]    = 1;
                    last_m[k] = (g[k] == 1);
                    eid[k]    = (g[k] == 1);
                    ed[k]     = (g[k] == 1) ? ref_rot(d1, s1, l1) : ref_rot(d0, s0, l0);
                end else if (busy_m[k]) begin
                    age[k]++;
                end
            end
            @(negedge clk);
        end
        v0 = 1'b0; v1 = 1'b0; resp_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; resp_ready = 1'b1;
        d0 = '0; d1 = '0; s0 = '0; s1 = '0;
        test_reset();
        test_single_right();
        test_left();
        test_fairness();
        test_back_pressure();
        test_reset_mid();
        test_latency();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
